res_quant_drain: RTL

RES_QUANT_DRAIN -- requirements
Module: res_quant_drain

---
 rtl/accelerator_config_pkg.sv | 13 +
 rtl/drain_fifo.sv | 48 ++++
 rtl/res_quant_drain.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/accelerator_config_pkg.sv
// Shared accelerator configuration: row capacity, signed 8-bit output bounds
// and the drain FSM state encoding.
package accelerator_config_pkg;
  localparam int MAX_ROWS = 16;
  localparam int QMIN     = -128;
  localparam int QMAX     = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_t;
endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO used as the drain output buffer; the head entry is read
// straight from storage, so it holds steady until it is popped.
module drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  // A push is still accepted when full if the head leaves in the same cycle.
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/res_quant_drain.sv
// Drains accumulator rows from the result BRAM, requantizes each to a signed
// OUT_WIDTH element and streams it out with index and last-element flag.
module res_quant_drain #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MAX_ROWS   = accelerator_config_pkg::MAX_ROWS,
  parameter int ADDR_WIDTH = $clog2(MAX_ROWS),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         num_rows,
  input  logic [15:0]                 scale,
  input  logic [4:0]                  shift,
  input  logic                        relu_en,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic signed [ACC_WIDTH-1:0] rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]       out_idx,
  output logic                        out_last
);
  import accelerator_config_pkg::*;

  localparam int PROD_W = ACC_WIDTH + 17;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int FW     = OUT_WIDTH + ADDR_WIDTH + 1;
  localparam int NW     = ADDR_WIDTH + 1;

  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [15:0]                 scl,
    input logic [4:0]                  sh
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(acc) * PROD_W'($signed({1'b0, scl}));
    if (sh != 5'd0) p = p + (PROD_W'(1) <<< (sh - 5'd1));
    return p >>> sh;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [PROD_W-1:0] v,
    input logic                     relu
  );
    logic signed [OUT_WIDTH-1:0] r;
    if (v > PROD_W'(QMAX))      r = OUT_WIDTH'(QMAX);
    else if (v < PROD_W'(QMIN)) r = OUT_WIDTH'(QMIN);
    else                        r = v[OUT_WIDTH-1:0];
    if (relu && r[OUT_WIDTH-1]) r = '0;
    return r;
  endfunction

  drain_state_t state, state_next;

  logic [NW-1:0]               n_clamped, n_lat, issue_cnt;
  logic [15:0]                 scale_lat;
  logic [4:0]                  shift_lat;
  logic                        relu_lat;
  logic                        accept, issue_start, issue_run, credit, pop;
  logic                        vld_p0, vld_p1;
  logic [ADDR_WIDTH-1:0]       idx_p0, idx_p1;
  logic signed [ACC_WIDTH-1:0] acc_p1;
  logic signed [OUT_WIDTH-1:0] q_p1;
  logic                        last_p1;
  logic [CW:0]                 occupancy;
  logic [FW-1:0]               fifo_dout;
  logic                        fifo_full, fifo_empty;
  logic [CW-1:0]               fifo_count;

  assign n_clamped   = (num_rows > NW'(MAX_ROWS)) ? NW'(MAX_ROWS) : num_rows;
  assign accept      = (state == IDLE) && start;
  assign issue_start = accept && (n_clamped != '0);
  assign pop         = out_valid && out_ready;
  // Elements already owed to the FIFO, net of the entry leaving this cycle.
  assign occupancy   = (CW+1)'(fifo_count) + (CW+1)'(rd_en) + (CW+1)'(vld_p0)
                     + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign credit      = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign issue_run   = (state == RUN) && (issue_cnt < n_lat) && credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = (n_clamped == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (pop && fifo_dout[FW-1]) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      n_lat     <= n_clamped;
      scale_lat <= scale;
      shift_lat <= shift;
      relu_lat  <= relu_en;
    end
  end

  // Issue stage: read request and address toward the BRAM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      issue_cnt <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      rd_en  <= issue_start || issue_run;
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      if (issue_start) begin
        rd_addr   <= '0;
        issue_cnt <= NW'(1);
      end else if (issue_run) begin
        rd_addr   <= issue_cnt[ADDR_WIDTH-1:0];
        issue_cnt <= issue_cnt + NW'(1);
      end
    end
  end

  // p0: BRAM data on rd_data; p1: captured accumulator in the quantize stage
  always_ff @(posedge clk) begin
    idx_p0 <= rd_addr;
    idx_p1 <= idx_p0;
    if (vld_p0) acc_p1 <= rd_data;
  end

  assign q_p1    = saturate(round_shift(acc_p1, scale_lat, shift_lat), relu_lat);
  assign last_p1 = (NW'(idx_p1) == (n_lat - NW'(1)));

  drain_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .pop   (pop),
    .din   ({last_p1, idx_p1, q_p1}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : $signed(fifo_dout[OUT_WIDTH-1:0]);
  assign out_idx   = fifo_empty ? '0 : fifo_dout[OUT_WIDTH +: ADDR_WIDTH];
  assign out_last  = !fifo_empty && fifo_dout[FW-1];
endmodule
